// File: rtl/vdp_slot_pkg.sv
// Shared types and constants for the MSX cartridge-slot front end of the VDP.
`timescale 1ns/1ps
package vdp_slot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        RD_REQ,
        RD_WAIT,
        RD_HOLD
    } slot_state_e;

    // Alternate base selectable by the port-select switch
    localparam logic [7:0] ALT_IO_BASE = 8'h98;

    localparam logic [1:0] PORT_VRAM_DATA = 2'd0;
    localparam logic [1:0] PORT_CONTROL   = 2'd1;
    localparam logic [1:0] PORT_PALETTE   = 2'd2;
    localparam logic [1:0] PORT_INDIRECT  = 2'd3;

    function automatic logic port_hit(input logic [7:0] addr, input logic [7:0] base);
        return addr[7:2] == base[7:2];
    endfunction

endpackage

// File: rtl/vdp_slot_sync.sv
// N-stage flop synchroniser with a configurable reset value.
`timescale 1ns/1ps
module vdp_slot_sync #(
    parameter int unsigned     WIDTH   = 1,
    parameter int unsigned     STAGES  = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] sr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr <= {STAGES{RST_VAL}};
        end else begin
            sr <= {sr[STAGES-2:0], d};
        end
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/vdp_cartridge_slot_if.sv
// MSX slot I/O front end: synchronises the Z80 bus, decodes the four VDP ports
// and bridges them to the VDP request bus. Optional: VDP_SLOT_DIPSW_PORT_SEL_EN.
`timescale 1ns/1ps
module vdp_cartridge_slot_if
    import vdp_slot_pkg::*;
#(
    parameter logic [7:0]  IO_BASE     = 8'h88,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       slot_iorq_n,
    input  logic       slot_rd_n,
    input  logic       slot_wr_n,
    input  logic [7:0] slot_a,
    input  logic [7:0] slot_d_in,
    output logic [7:0] slot_d_out,
    output logic       slot_data_dir,
    output logic       busdir,
    output logic       oe_n,
    output logic       slot_wait,
    output logic       slot_intr,
    input  logic       dipsw,
    input  logic       init_done,
    output logic [1:0] bus_address,
    output logic       bus_write,
    output logic [7:0] bus_wdata,
    output logic       bus_valid,
    input  logic       bus_ready,
    input  logic [7:0] bus_rdata,
    input  logic       bus_rdata_en,
    input  logic       vdp_int_n
);

    logic [2:0]  strobe_s;
    logic        iorq_s;
    logic        rd_s;
    logic        wr_s;
    logic [7:0]  a_s;
    logic [7:0]  d_s;
    logic [7:0]  selected_base;
    logic        hit_c;
    logic        wr_cond_c;
    logic        rd_cond_c;
    logic        armed;
    slot_state_e state;

    vdp_slot_sync #(.WIDTH(3), .STAGES(SYNC_STAGES), .RST_VAL(3'b111)) u_sync_strobe (
        .clk     (clk),
        .reset_n (reset_n),
        .d       ({slot_iorq_n, slot_rd_n, slot_wr_n}),
        .q       (strobe_s)
    );

    vdp_slot_sync #(.WIDTH(8), .STAGES(SYNC_STAGES), .RST_VAL(8'h00)) u_sync_addr (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (slot_a),
        .q       (a_s)
    );

    vdp_slot_sync #(.WIDTH(8), .STAGES(SYNC_STAGES), .RST_VAL(8'h00)) u_sync_data (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (slot_d_in),
        .q       (d_s)
    );

`ifdef VDP_SLOT_DIPSW_PORT_SEL_EN
    logic dipsw_s;

    vdp_slot_sync #(.WIDTH(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_dipsw (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (dipsw),
        .q       (dipsw_s)
    );

    assign selected_base = dipsw_s ? ALT_IO_BASE : IO_BASE;
`else
    logic unused_dipsw;

    assign unused_dipsw  = dipsw;
    assign selected_base = IO_BASE;
`endif

    assign iorq_s    = strobe_s[2];
    assign rd_s      = strobe_s[1];
    assign wr_s      = strobe_s[0];
    assign hit_c     = port_hit(a_s, selected_base);
    assign wr_cond_c = ~iorq_s & ~wr_s & hit_c;
    assign rd_cond_c = ~iorq_s & ~rd_s & hit_c;

    // Request FSM; armed re-arms only once the strobes have been released,
    // so a held strobe (or one already low when init completes) yields nothing new.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            armed         <= 1'b0;
            bus_valid     <= 1'b0;
            bus_write     <= 1'b0;
            bus_address   <= 2'd0;
            bus_wdata     <= 8'h00;
            slot_d_out    <= 8'h00;
            slot_data_dir <= 1'b0;
            slot_wait     <= 1'b1;
        end else begin
            slot_wait <= ~init_done;
            if (!init_done) begin
                armed <= 1'b0;
            end else if (!wr_cond_c && !rd_cond_c) begin
                armed <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (init_done && armed) begin
                        if (wr_cond_c) begin
                            state       <= WR_REQ;
                            armed       <= 1'b0;
                            bus_valid   <= 1'b1;
                            bus_write   <= 1'b1;
                            bus_address <= a_s[1:0];
                            bus_wdata   <= d_s;
                        end else if (rd_cond_c) begin
                            state       <= RD_REQ;
                            armed       <= 1'b0;
                            bus_valid   <= 1'b1;
                            bus_write   <= 1'b0;
                            bus_address <= a_s[1:0];
                            slot_wait   <= 1'b1;
                        end
                    end
                end
                WR_REQ: begin
                    if (bus_ready) begin
                        state     <= IDLE;
                        bus_valid <= 1'b0;
                        bus_write <= 1'b0;
                    end
                end
                RD_REQ: begin
                    slot_wait <= 1'b1;
                    if (bus_ready) begin
                        bus_valid <= 1'b0;
                        if (bus_rdata_en) begin
                            state         <= RD_HOLD;
                            slot_d_out    <= bus_rdata;
                            slot_data_dir <= 1'b1;
                            slot_wait     <= ~init_done;
                        end else begin
                            state <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    slot_wait <= 1'b1;
                    if (bus_rdata_en) begin
                        state         <= RD_HOLD;
                        slot_d_out    <= bus_rdata;
                        slot_data_dir <= 1'b1;
                        slot_wait     <= ~init_done;
                    end
                end
                RD_HOLD: begin
                    if (rd_s || iorq_s) begin
                        state         <= IDLE;
                        slot_data_dir <= 1'b0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus_valid     <= 1'b0;
                    bus_write     <= 1'b0;
                    slot_data_dir <= 1'b0;
                end
            endcase
        end
    end

    // Level-shifter enable and interrupt pass-through
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            oe_n      <= 1'b1;
            slot_intr <= 1'b0;
        end else begin
            oe_n      <= 1'b0;
            slot_intr <= ~vdp_int_n;
        end
    end

    assign busdir = slot_data_dir;

endmodule

// File: tb/tb_vdp_cartridge_slot_if.sv
// Self-checking bench for vdp_cartridge_slot_if: Z80 bus tasks, a VDP bus responder
// and a transaction/rule model checked every cycle.
`timescale 1ns/1ps
module tb_vdp_cartridge_slot_if;

    typedef struct packed {
        logic       w;
        logic [1:0] a;
        logic [7:0] d;
    } txn_t;

    logic       clk;
    logic       reset_n;
    logic       slot_iorq_n;
    logic       slot_rd_n;
    logic       slot_wr_n;
    logic [7:0] slot_a;
    logic [7:0] slot_d_in;
    logic [7:0] slot_d_out;
    logic       slot_data_dir;
    logic       busdir;
    logic       oe_n;
    logic       slot_wait;
    logic       slot_intr;
    logic       dipsw;
    logic       init_done;
    logic [1:0] bus_address;
    logic       bus_write;
    logic [7:0] bus_wdata;
    logic       bus_valid;
    logic       bus_ready;
    logic [7:0] bus_rdata;
    logic       bus_rdata_en;
    logic       vdp_int_n;

    int checks = 0;
    int errors = 0;

    txn_t       exp_q[$];
    int         acc_cnt = 0;
    logic       last_w;
    logic [1:0] last_a;
    logic [7:0] last_d;
    logic [7:0] rd_data = 8'h00;
    int         rd_lat = 20;
    int         stall = 0;
    logic       int_q, init_q, rd_outstanding, rd_served;
    int         up_cycles, rel_cnt;

    vdp_cartridge_slot_if #(.IO_BASE(8'h88), .SYNC_STAGES(2)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .slot_iorq_n   (slot_iorq_n),
        .slot_rd_n     (slot_rd_n),
        .slot_wr_n     (slot_wr_n),
        .slot_a        (slot_a),
        .slot_d_in     (slot_d_in),
        .slot_d_out    (slot_d_out),
        .slot_data_dir (slot_data_dir),
        .busdir        (busdir),
        .oe_n          (oe_n),
        .slot_wait     (slot_wait),
        .slot_intr     (slot_intr),
        .dipsw         (dipsw),
        .init_done     (init_done),
        .bus_address   (bus_address),
        .bus_write     (bus_write),
        .bus_wdata     (bus_wdata),
        .bus_valid     (bus_valid),
        .bus_ready     (bus_ready),
        .bus_rdata     (bus_rdata),
        .bus_rdata_en  (bus_rdata_en),
        .vdp_int_n     (vdp_int_n)
    );

    initial clk = 1'b0;
    always #5.82 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_hit(input logic [7:0] a);
        logic [7:0] base;
        base = 8'h88;
`ifdef VDP_SLOT_DIPSW_PORT_SEL_EN
        if (dipsw) base = 8'h98;
`endif
        return a[7:2] == base[7:2];
    endfunction

    // Z80 I/O write cycle; a hit while initialised must produce exactly one request
    task automatic z80_wr(input logic [7:0] a, input logic [7:0] d, input int hold_ns);
        if (init_done && exp_hit(a)) exp_q.push_back({1'b1, a[1:0], d});
        slot_a = a;
        slot_d_in = d;
        #60;
        slot_iorq_n = 1'b0;
        #10;
        slot_wr_n = 1'b0;
        #(hold_ns);
        slot_wr_n = 1'b1;
        #10;
        slot_iorq_n = 1'b1;
        #150;
    endtask

    // Z80 I/O read cycle honouring WAIT; undriven bus reads as 0xFF
    task automatic z80_rd(input logic [7:0] a, output logic [7:0] q);
        int n;
        if (init_done && exp_hit(a)) exp_q.push_back({1'b0, a[1:0], 8'h00});
        slot_a = a;
        #60;
        slot_iorq_n = 1'b0;
        slot_rd_n = 1'b0;
        #100;
        n = 0;
        while (slot_wait && n < 2000) begin
            #10;
            n++;
        end
        if (n >= 2000) begin
            checks++;
            errors++;
            $display("FAIL rd_wait_timeout: got slot_wait=1 for 20us required release");
        end
        #50;
        q = slot_data_dir ? slot_d_out : 8'hFF;
        slot_rd_n = 1'b1;
        slot_iorq_n = 1'b1;
        #150;
        chk("rd_release_dir", 32'(slot_data_dir), 32'd0);
    endtask

    // VDP bus responder: optional ready stall and read-data latency
    initial begin : responder
        int wcnt;
        int rd_cnt;
        wcnt = 0;
        rd_cnt = -1;
        bus_ready = 1'b0;
        bus_rdata = 8'h00;
        bus_rdata_en = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) begin
                bus_ready = 1'b0;
                bus_rdata_en = 1'b0;
                wcnt = 0;
                rd_cnt = -1;
            end else begin
                bus_rdata_en = 1'b0;
                if (rd_cnt == 0) begin
                    bus_rdata_en = 1'b1;
                    bus_rdata = rd_data;
                    rd_cnt = -1;
                end else if (rd_cnt > 0) begin
                    rd_cnt--;
                end
                if (bus_valid && !bus_ready && wcnt >= stall) begin
                    bus_ready = 1'b1;
                    wcnt = 0;
                    if (!bus_write) begin
                        if (rd_lat == 0) begin
                            bus_rdata_en = 1'b1;
                            bus_rdata = rd_data;
                        end else begin
                            rd_cnt = rd_lat - 1;
                        end
                    end
                end else begin
                    bus_ready = 1'b0;
                    if (bus_valid) wcnt++;
                    else wcnt = 0;
                end
            end
        end
    end

    // Per-cycle model check: outputs against the rules, requests against the queue
    initial begin : compare
        txn_t e;
        int_q = 1'b0;
        init_q = 1'b0;
        rd_outstanding = 1'b0;
        rd_served = 1'b0;
        up_cycles = 0;
        rel_cnt = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                int_q = 1'b0;
                init_q = 1'b0;
                rd_outstanding = 1'b0;
                rd_served = 1'b0;
                up_cycles = 0;
                rel_cnt = 0;
            end else begin
                if (slot_rd_n || slot_iorq_n) rel_cnt++;
                else rel_cnt = 0;
                if (rel_cnt >= 4) rd_served = 1'b0;
                chk("busdir", 32'(busdir), 32'(slot_data_dir));
                chk("intr", 32'(slot_intr), 32'(int_q));
                if (up_cycles >= 1) chk("oe_n", 32'(oe_n), 32'd0);
                if (!init_q) begin
                    chk("init_wait", 32'(slot_wait), 32'd1);
                    chk("init_valid", 32'(bus_valid), 32'd0);
                end
                if (rd_outstanding) begin
                    chk("rd_pending_wait", 32'(slot_wait), 32'd1);
                    chk("rd_pending_dir", 32'(slot_data_dir), 32'd0);
                end
                if (!rd_served) chk("spurious_dir", 32'(slot_data_dir), 32'd0);
                else if (slot_data_dir) chk("rd_dout", 32'(slot_d_out), 32'(rd_data));
                if (bus_valid && bus_ready) begin
                    acc_cnt++;
                    last_w = bus_write;
                    last_a = bus_address;
                    last_d = bus_wdata;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_req: got w=%0b a=%0d d=0x%0h required none",
                                 bus_write, bus_address, bus_wdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("req_write", 32'(bus_write), 32'(e.w));
                        chk("req_addr", 32'(bus_address), 32'(e.a));
                        if (e.w) chk("req_wdata", 32'(bus_wdata), 32'(e.d));
                    end
                    if (!bus_write) rd_outstanding = 1'b1;
                end
                if (bus_rdata_en) begin
                    rd_outstanding = 1'b0;
                    rd_served = 1'b1;
                    rel_cnt = 0;
                end
                int_q = ~vdp_int_n;
                init_q = init_done;
                up_cycles++;
            end
        end
    end

    initial begin : watchdog
        #3ms;
        $display("FAIL watchdog: got no finish by 3ms required completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int         a0;
        int         n;
        logic [7:0] q;
        reset_n = 1'b0;
        slot_iorq_n = 1'b1;
        slot_rd_n = 1'b1;
        slot_wr_n = 1'b1;
        slot_a = 8'h00;
        slot_d_in = 8'h00;
        dipsw = 1'b0;
        init_done = 1'b0;
        vdp_int_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_dout", 32'(slot_d_out), 32'd0);
        chk("rst_dir", 32'(slot_data_dir), 32'd0);
        chk("rst_busdir", 32'(busdir), 32'd0);
        chk("rst_oe_n", 32'(oe_n), 32'd1);
        chk("rst_wait", 32'(slot_wait), 32'd1);
        chk("rst_intr", 32'(slot_intr), 32'd0);
        chk("rst_valid", 32'(bus_valid), 32'd0);
        chk("rst_write", 32'(bus_write), 32'd0);
        chk("rst_addr", 32'(bus_address), 32'd0);
        chk("rst_wdata", 32'(bus_wdata), 32'd0);
        reset_n = 1'b1;

        // Strobes before init are ignored; WAIT held
        z80_wr(8'h89, 8'h11, 125);
        repeat (100) @(posedge clk);
        #1;
        chk("init_wait_held", 32'(slot_wait), 32'd1);
        chk("init_no_req", 32'(acc_cnt), 32'd0);
        init_done = 1'b1;
        n = 0;
        while (slot_wait && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("init_wait_latency", 32'(n <= 2), 32'd1);
        chk("oe_n_on", 32'(oe_n), 32'd0);

        // Single write 0x04 to 0x89
        a0 = acc_cnt;
        z80_wr(8'h89, 8'h04, 125);
        chk("wr1_count", 32'(acc_cnt - a0), 32'd1);
        chk("wr1_write", 32'(last_w), 32'd1);
        chk("wr1_addr", 32'(last_a), 32'd1);
        chk("wr1_data", 32'(last_d), 32'h04);

        // Back-to-back writes, then a long stalled stream
        a0 = acc_cnt;
        z80_wr(8'h89, 8'h04, 125);
        z80_wr(8'h89, 8'h80, 125);
        stall = 10;
        for (int i = 0; i < 960; i++) z80_wr(8'h88, 8'(i * 7 + 3), 125);
        stall = 0;
        chk("stream_count", 32'(acc_cnt - a0), 32'd962);
        chk("stream_drained", 32'(exp_q.size()), 32'd0);
        chk("stream_last_data", 32'(last_d), 32'(8'((959 * 7 + 3) & 8'hFF)));

        // Held strobe gives one request; rd+wr together is a write
        a0 = acc_cnt;
        z80_wr(8'h8B, 8'h3C, 2000);
        chk("held_count", 32'(acc_cnt - a0), 32'd1);
        a0 = acc_cnt;
        exp_q.push_back({1'b1, 2'd2, 8'h66});
        slot_a = 8'h8A;
        slot_d_in = 8'h66;
        #60;
        slot_iorq_n = 1'b0;
        slot_rd_n = 1'b0;
        slot_wr_n = 1'b0;
        #125;
        slot_iorq_n = 1'b1;
        slot_rd_n = 1'b1;
        slot_wr_n = 1'b1;
        #150;
        chk("rdwr_count", 32'(acc_cnt - a0), 32'd1);
        chk("rdwr_is_write", 32'(last_w), 32'd1);
        chk("rdwr_dir", 32'(slot_data_dir), 32'd0);

        // Reads: 20-clock latency, then same-cycle ready+data
        rd_data = 8'h5A;
        rd_lat = 20;
        z80_rd(8'h88, q);
        chk("rd1_data", 32'(q), 32'h5A);
        chk("rd1_write", 32'(last_w), 32'd0);
        chk("rd1_addr", 32'(last_a), 32'd0);
        rd_data = 8'hA5;
        rd_lat = 0;
        z80_rd(8'h8B, q);
        chk("rd2_data", 32'(q), 32'hA5);
        chk("rd2_addr", 32'(last_a), 32'd3);

        // Misses
        a0 = acc_cnt;
        z80_rd(8'h98, q);
        chk("miss_rd_data", 32'(q), 32'hFF);
        z80_wr(8'h98, 8'h55, 125);
        chk("miss_count", 32'(acc_cnt - a0), 32'd0);

        // Port-select switch
        dipsw = 1'b1;
        repeat (4) @(posedge clk);
        a0 = acc_cnt;
        z80_wr(8'h98, 8'h77, 125);
`ifdef VDP_SLOT_DIPSW_PORT_SEL_EN
        chk("dipsw_count", 32'(acc_cnt - a0), 32'd1);
        chk("dipsw_addr", 32'(last_a), 32'd0);
        chk("dipsw_data", 32'(last_d), 32'h77);
`else
        chk("dipsw_ignored", 32'(acc_cnt - a0), 32'd0);
`endif
        dipsw = 1'b0;
        repeat (4) @(posedge clk);

        // Interrupt follows inverted with one clock latency
        @(posedge clk);
        #1;
        vdp_int_n = 1'b0;
        @(negedge clk);
        chk("intr_pre", 32'(slot_intr), 32'd0);
        @(negedge clk);
        chk("intr_set", 32'(slot_intr), 32'd1);
        @(posedge clk);
        #1;
        vdp_int_n = 1'b1;
        @(negedge clk);
        chk("intr_hold", 32'(slot_intr), 32'd1);
        @(negedge clk);
        chk("intr_clr", 32'(slot_intr), 32'd0);

        // Reset during RD_HOLD releases the bus at once
        rd_data = 8'hC3;
        rd_lat = 5;
        exp_q.push_back({1'b0, 2'd1, 8'h00});
        slot_a = 8'h89;
        #60;
        slot_iorq_n = 1'b0;
        slot_rd_n = 1'b0;
        n = 0;
        while (!slot_data_dir && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("hold_reached", 32'(slot_data_dir), 32'd1);
        #3;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_dir", 32'(slot_data_dir), 32'd0);
        chk("mid_rst_busdir", 32'(busdir), 32'd0);
        chk("mid_rst_oe_n", 32'(oe_n), 32'd1);
        chk("mid_rst_wait", 32'(slot_wait), 32'd1);
        chk("mid_rst_dout", 32'(slot_d_out), 32'd0);
        slot_rd_n = 1'b1;
        slot_iorq_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (4) @(posedge clk);

        a0 = acc_cnt;
        z80_wr(8'h89, 8'h42, 125);
        chk("post_rst_count", 32'(acc_cnt - a0), 32'd1);
        chk("post_rst_data", 32'(last_d), 32'h42);
        chk("final_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
